// File: rtl/cnn_pkg.sv
// Constants shared between the window generator and the convolution stage.
package cnn_pkg;
  localparam int PIX_W     = 4;
  localparam int KER_W     = 4;
  localparam int SUM_W     = 16;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
endpackage

// File: rtl/conv_line_buffer.sv
// Enabled delay line: dout is the sample written DEPTH enabled cycles ago.
module conv_line_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the window's validity gating guarantees stale entries are never used.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register window,
// flagging only windows that lie fully inside the image.
module conv_window_gen #(
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int IMG_W = cnn_pkg::IMG_W_DEF,
  parameter int IMG_H = cnn_pkg::IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             win_valid,
  output logic [PIX_W-1:0] pixel1,
  output logic [PIX_W-1:0] pixel2,
  output logic [PIX_W-1:0] pixel3,
  output logic [PIX_W-1:0] pixel4,
  output logic [PIX_W-1:0] pixel5,
  output logic [PIX_W-1:0] pixel6,
  output logic [PIX_W-1:0] pixel7,
  output logic [PIX_W-1:0] pixel8,
  output logic [PIX_W-1:0] pixel9,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             col_last;
  logic             row_last;
  logic [PIX_W-1:0] lb0_out;
  logic [PIX_W-1:0] lb1_out;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // lb0 yields the pixel one row above, lb1 the pixel two rows above.
  conv_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .en   (pix_valid),
    .din  (pix_in),
    .dout (lb0_out)
  );

  conv_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (pix_valid),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      pixel1 <= '0; pixel2 <= '0; pixel3 <= '0;
      pixel4 <= '0; pixel5 <= '0; pixel6 <= '0;
      pixel7 <= '0; pixel8 <= '0; pixel9 <= '0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        // Windows whose left columns wrap from the previous row are never flagged.
        win_valid  <= (row >= RW'(2)) && (col >= CW'(2));
        frame_done <= row_last && col_last;
        pixel1 <= pixel2; pixel2 <= pixel3; pixel3 <= lb1_out;
        pixel4 <= pixel5; pixel5 <= pixel6; pixel6 <= lb0_out;
        pixel7 <= pixel8; pixel8 <= pixel9; pixel9 <= pix_in;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen (5x5 and 3x3 instances) against an
// image-array reference model.
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pv5, pv3;
  logic [3:0] pi5, pi3;
  logic       wv5, wv3, fd5, fd3;
  logic [3:0] w5 [9];
  logic [3:0] w3 [9];

  conv_window_gen #(.PIX_W(4), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv5), .pix_in(pi5), .win_valid(wv5),
    .pixel1(w5[0]), .pixel2(w5[1]), .pixel3(w5[2]), .pixel4(w5[3]), .pixel5(w5[4]),
    .pixel6(w5[5]), .pixel7(w5[6]), .pixel8(w5[7]), .pixel9(w5[8]), .frame_done(fd5)
  );

  conv_window_gen #(.PIX_W(4), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv3), .pix_in(pi3), .win_valid(wv3),
    .pixel1(w3[0]), .pixel2(w3[1]), .pixel3(w3[2]), .pixel4(w3[3]), .pixel5(w3[4]),
    .pixel6(w3[5]), .pixel7(w3[6]), .pixel8(w3[7]), .pixel9(w3[8]), .frame_done(fd3)
  );

  int tests  = 0;
  int errors = 0;

  // Reference model: frame image per instance, pixel index since reset.
  int dim [2] = '{5, 3};
  int kpos[2] = '{0, 0};
  int img [2][5][5];

  // Per-test observations.
  int          win_cnt, fd_cnt, acc_cnt;
  int          fd_idx[$];
  logic [35:0] first_win, last_win;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    win_cnt = 0; fd_cnt = 0; acc_cnt = 0;
    fd_idx.delete();
    first_win = '0; last_win = '0;
  endtask

  function automatic logic [35:0] pack_obs(input int s);
    logic [35:0] v;
    for (int i = 0; i < 9; i++) v[35-4*i -: 4] = (s == 0) ? w5[i] : w3[i];
    return v;
  endfunction

  // One clock cycle on instance s; v=0 is an idle (gap) cycle.
  task automatic step(input int s, input bit v, input logic [3:0] p);
    int r, c, n;
    bit exp_v, exp_fd;
    logic [35:0] exp_win, got_win;
    logic got_v, got_fd;
    exp_v = 0; exp_fd = 0; exp_win = '0;
    @(negedge clk);
    pv5 = (s == 0) && v; pi5 = p;
    pv3 = (s == 1) && v; pi3 = p;
    if (v) begin
      n = dim[s];
      r = kpos[s] / n;
      c = kpos[s] % n;
      img[s][r][c] = int'(p);
      exp_v  = (r >= 2) && (c >= 2);
      exp_fd = (r == n - 1) && (c == n - 1);
      if (exp_v)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[35-4*(3*i+j) -: 4] = 4'(img[s][r-2+i][c-2+j]);
      kpos[s] = (kpos[s] + 1) % (n * n);
    end
    @(posedge clk);
    #1;
    got_v   = (s == 0) ? wv5 : wv3;
    got_fd  = (s == 0) ? fd5 : fd3;
    got_win = pack_obs(s);
    check("win_valid", 64'(got_v), 64'(exp_v));
    check("frame_done", 64'(got_fd), 64'(exp_fd));
    if (exp_v) begin
      check("window", 64'(got_win), 64'(exp_win));
      if (win_cnt == 0) first_win = got_win;
      last_win = got_win;
    end
    if (got_v) win_cnt++;
    if (v) acc_cnt++;
    if (got_fd) begin
      fd_cnt++;
      fd_idx.push_back(acc_cnt - 1);
    end
    pv5 = 1'b0; pv3 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pv5 = 1'b0; pv3 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_win_valid", 64'({wv5, wv3}), 64'(0));
    check("rst_frame_done", 64'({fd5, fd3}), 64'(0));
    check("rst_pixels5", 64'(pack_obs(0)), 64'(0));
    check("rst_pixels3", 64'(pack_obs(1)), 64'(0));
    kpos[0] = 0; kpos[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: (5r+c) mod 16, mode 1: random values, mode 2: 1..N*N
  task automatic send_frame(input int s, input int mode, input bit gaps, input int npix);
    int n;
    logic [3:0] p;
    n = dim[s];
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       p = 4'((5 * (i / n) + (i % n)) % 16);
        1:       p = 4'($urandom_range(0, 15));
        default: p = 4'(i + 1);
      endcase
      step(s, 1'b1, p);
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) step(s, 1'b0, 4'($urandom_range(0, 15)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; pv5 = 1'b0; pv3 = 1'b0; pi5 = '0; pi3 = '0;
    do_reset();

    // Basic fill and row-wrap gating.
    clear_obs();
    send_frame(0, 0, 1'b0, 25);
    check("fill_win_count", 64'(win_cnt), 64'(9));
    check("fill_first_win", 64'(first_win), 64'h012567ABC);
    check("fill_last_win", 64'(last_win), 64'hCDE123678);
    check("fill_fd_count", 64'(fd_cnt), 64'(1));

    // Same image with random stalls.
    clear_obs();
    send_frame(0, 0, 1'b1, 25);
    check("stall_win_count", 64'(win_cnt), 64'(9));
    check("stall_first_win", 64'(first_win), 64'h012567ABC);
    check("stall_last_win", 64'(last_win), 64'hCDE123678);

    // Back-to-back frames.
    clear_obs();
    send_frame(0, 0, 1'b0, 25);
    check("b2b_first_win", 64'(first_win), 64'h012567ABC);
    win_cnt = 0;
    send_frame(0, 0, 1'b0, 25);
    check("b2b_second_first_win", 64'(first_win), 64'h012567ABC);
    check("b2b_fd_count", 64'(fd_cnt), 64'(2));
    if (fd_idx.size() == 2) begin
      check("b2b_fd_idx0", 64'(fd_idx[0]), 64'(24));
      check("b2b_fd_idx1", 64'(fd_idx[1]), 64'(49));
    end else begin
      check("b2b_fd_idx_size", 64'(fd_idx.size()), 64'(2));
    end

    // Reset mid-frame.
    send_frame(0, 1, 1'b0, 8);
    do_reset();
    clear_obs();
    send_frame(0, 0, 1'b0, 25);
    check("midrst_win_count", 64'(win_cnt), 64'(9));
    check("midrst_first_win", 64'(first_win), 64'h012567ABC);

    // Random data with random gaps.
    for (int f = 0; f < 4; f++) begin
      clear_obs();
      send_frame(0, 1, 1'b1, 25);
      check("rand_win_count", 64'(win_cnt), 64'(9));
      check("rand_fd_count", 64'(fd_cnt), 64'(1));
    end

    // Minimum image size.
    clear_obs();
    send_frame(1, 2, 1'b0, 9);
    check("min_win_count", 64'(win_cnt), 64'(1));
    check("min_window", 64'(first_win), 64'h123456789);
    check("min_fd_idx", 64'((fd_idx.size() == 1) ? fd_idx[0] : -1), 64'(8));
    clear_obs();
    send_frame(1, 1, 1'b1, 9);
    check("min_rand_win_count", 64'(win_cnt), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
